// File: rtl/wfg_core_sequencer_if.sv
// Interface: wfg_core_sequencer_if
// Bundles the register-file controls feeding the sequencer and the timing
// strobes it drives towards the stimulus and driver blocks.
// Optional macro WFG_CORE_SEQ_FRAMECNT_EN adds the 32-bit frame_cnt_o signal.
interface wfg_core_sequencer_if #(
  parameter int SUBW  = 16,
  parameter int SYNCW = 8
);
  logic             ctrl_en_q_i;
  logic [SUBW-1:0]  cfg_subcycle_q_i;
  logic [SYNCW-1:0] cfg_sync_q_i;
  logic             wfg_subcycle_o;
  logic             wfg_sync_o;
  logic [SYNCW-1:0] wfg_subcycle_cnt_o;
  logic             active_o;
`ifdef WFG_CORE_SEQ_FRAMECNT_EN
  logic [31:0]      frame_cnt_o;
`endif

  // Register-file side: drives enable and configuration, observes strobes
  modport master (
    output ctrl_en_q_i, cfg_subcycle_q_i, cfg_sync_q_i,
    input  wfg_subcycle_o, wfg_sync_o, wfg_subcycle_cnt_o, active_o
`ifdef WFG_CORE_SEQ_FRAMECNT_EN
    , input frame_cnt_o
`endif
  );

  // Sequencer side
  modport slave (
    input  ctrl_en_q_i, cfg_subcycle_q_i, cfg_sync_q_i,
    output wfg_subcycle_o, wfg_sync_o, wfg_subcycle_cnt_o, active_o
`ifdef WFG_CORE_SEQ_FRAMECNT_EN
    , output frame_cnt_o
`endif
  );
endinterface

// File: rtl/wfg_core_sequencer.sv
// Module: wfg_core_sequencer
// Divides clk into subcycles of (sub+1) clocks and groups (sync+1) subcycles
// into a frame. Configuration is shadowed and only picked up at frame
// boundaries; dropping the enable lets the current frame run to completion.
// Optional macro WFG_CORE_SEQ_FRAMECNT_EN adds a completed-frame counter.
module wfg_core_sequencer #(
  parameter int SUBW  = 16,
  parameter int SYNCW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wfg_core_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } seqState_t;

  seqState_t        r_state;
  logic [SUBW-1:0]  r_scCnt;
  logic [SYNCW-1:0] r_syCnt;
  logic [SUBW-1:0]  r_subSh;
  logic [SYNCW-1:0] r_syncSh;

  logic w_en;
  logic w_active;
  logic w_scEnd;
  logic w_frEnd;

  assign w_en     = bus.ctrl_en_q_i;
  assign w_active = (r_state != IDLE);
  assign w_scEnd  = (r_scCnt == r_subSh);
  assign w_frEnd  = w_scEnd && (r_syCnt == r_syncSh);

  // Sequencer FSM plus subcycle/frame counters and configuration shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_scCnt  <= '0;
      r_syCnt  <= '0;
      r_subSh  <= '0;
      r_syncSh <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_en) begin
            r_state  <= RUN;
            r_scCnt  <= '0;
            r_syCnt  <= '0;
            r_subSh  <= bus.cfg_subcycle_q_i;
            r_syncSh <= bus.cfg_sync_q_i;
          end
        end
        RUN, STOP: begin
          if (w_scEnd) begin
            r_scCnt <= '0;
            if (w_frEnd) begin
              r_syCnt  <= '0;
              r_subSh  <= bus.cfg_subcycle_q_i;
              r_syncSh <= bus.cfg_sync_q_i;
            end else begin
              r_syCnt <= r_syCnt + 1'b1;
            end
          end else begin
            r_scCnt <= r_scCnt + 1'b1;
          end

          if (r_state == RUN) begin
            if (!w_en) r_state <= STOP;
          end else if (w_frEnd) begin
            r_state <= w_en ? RUN : IDLE;
          end else if (w_en) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wfg_subcycle_o     = w_active && w_scEnd;
  assign bus.wfg_sync_o         = w_active && w_frEnd;
  assign bus.wfg_subcycle_cnt_o = r_syCnt;
  assign bus.active_o           = w_active;

`ifdef WFG_CORE_SEQ_FRAMECNT_EN
  logic [31:0] r_frameCnt;

  // Completed-frame counter, restarted whenever the sequencer starts from idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
    end else if ((r_state == IDLE) && w_en) begin
      r_frameCnt <= '0;
    end else if (w_active && w_frEnd) begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  assign bus.frame_cnt_o = r_frameCnt;
`endif

endmodule
